mealy_seq_detect: RTL and testbench

Parametrised Mealy-style serial pattern detector. It is the successor to the single-flag Mealy FSM. It watches a 1-bit serial input, one bit per enabled clock, for a configurable PATTERN. It asserts sm_out combinationally in the same cycle the final pattern bit is present on flag. It adds an overlap/non-overlap mode, a clock enable, a synchronous clear and a saturating hit counter. Used in sandbox FSM experiments and as a framing/sync-word detector front end.

---
 rtl/mealy_seq_detect.sv | 131 +++++++++++++
 tb/tb_mealy_seq_detect.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_detect.sv
// Mealy serial pattern detector with overlap mode, clock enable, synchronous clear and a
// saturating hit counter.
//
// Parameters:
//   PATTERN_W - pattern length in bits, 2..16
//   PATTERN   - pattern to match, MSB is the first bit received
//   OVERLAP   - 1: overlapping matches allowed; 0: restart from empty after a match
//   COUNT_W   - width of hit_count
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   en        - bit valid; flag is sampled only when en=1
//   clr       - synchronous clear of state and hit_count, highest priority
//   flag      - serial input bit
//   sm_out    - combinational match output, high while the final pattern bit is on flag
//   hit_count - saturating count of matches since reset/clear
module mealy_seq_detect #(
  parameter int unsigned          PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int unsigned          COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic               flag,
  output logic               sm_out,
  output logic [COUNT_W-1:0] hit_count
);

  if (PATTERN_W < 2 || PATTERN_W > 16) begin : gen_bad_width
    $error("mealy_seq_detect: PATTERN_W must be in 2..16");
  end

  localparam int unsigned     StW    = $clog2(PATTERN_W);
  localparam int unsigned     NumEnc = 2 ** StW;
  localparam logic [StW-1:0]  LastSt = StW'(PATTERN_W - 1);

  // i-th received bit of the pattern (0 = first).
  function automatic logic pat_bit(input int unsigned i);
    return PATTERN[PATTERN_W-1-i];
  endfunction

  // KMP failure function: longest proper border of the pattern prefix of length len.
  function automatic int unsigned kmp_fail(input int unsigned len);
    int unsigned res;
    bit          ok;
    res = 0;
    for (int l = 1; l < int'(len); l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        if (pat_bit(i) != pat_bit(len - l + i)) ok = 1'b0;
      end
      if (ok) res = l;
    end
    return res;
  endfunction

  // KMP automaton transition from state k on bit b; evaluated only at elaboration.
  function automatic int unsigned delta(input int unsigned k, input logic b);
    int unsigned j;
    int unsigned res;
    bit          done;
    j    = k;
    res  = 0;
    done = 1'b0;
    // j strictly decreases on every fallback, so PATTERN_W+1 passes always settle.
    for (int it = 0; it <= int'(PATTERN_W); it++) begin
      if (!done) begin
        if (b == pat_bit(j)) begin
          if (j == PATTERN_W - 1) res = OVERLAP ? kmp_fail(PATTERN_W) : 0;
          else                    res = j + 1;
          done = 1'b1;
        end else if (j == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          j = kmp_fail(j);
        end
      end
    end
    return res;
  endfunction

  // Constant next-state tables indexed by current state; unused encodings fall back to 0.
  logic [StW-1:0] nxt0 [NumEnc];
  logic [StW-1:0] nxt1 [NumEnc];

  for (genvar k = 0; k < NumEnc; k++) begin : gen_tbl
    if (k < PATTERN_W) begin : gen_live
      localparam int unsigned Nxt0 = delta(k, 1'b0);
      localparam int unsigned Nxt1 = delta(k, 1'b1);
      assign nxt0[k] = StW'(Nxt0);
      assign nxt1[k] = StW'(Nxt1);
    end else begin : gen_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  logic [StW-1:0]     st_q, st_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sm_out = reset & en & ~clr & (st_q == LastSt) & (flag == PATTERN[0]);
    if (clr) begin
      st_d  = '0;
      cnt_d = '0;
    end else if (en) begin
      st_d = flag ? nxt1[st_q] : nxt0[st_q];
      if (sm_out && (cnt_q != '1)) cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign hit_count = cnt_q;

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Directed bench for mealy_seq_detect. Three instances share one stimulus stream:
// overlapping (8-bit count), non-overlapping (8-bit count) and overlapping with a 2-bit
// saturating count. Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_mealy_seq_detect;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       flag;
  logic       sm_ovl, sm_novl, sm_sat;
  logic [7:0] cnt_ovl, cnt_novl;
  logic [1:0] cnt_sat;

  int n_tests;
  int n_fail;

  mealy_seq_detect #(
    .PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)
  ) u_dut_ovl (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .flag(flag),
    .sm_out(sm_ovl), .hit_count(cnt_ovl)
  );

  mealy_seq_detect #(
    .PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)
  ) u_dut_novl (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .flag(flag),
    .sm_out(sm_novl), .hit_count(cnt_novl)
  );

  mealy_seq_detect #(
    .PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(2)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .flag(flag),
    .sm_out(sm_sat), .hit_count(cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic f, input logic e, input logic c);
    @(negedge clk);
    flag = f;
    en   = e;
    clr  = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    flag  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [6:0]  s7;
  logic [6:0]  exp_ovl7;
  logic [6:0]  exp_novl7;
  logic [15:0] s16;
  logic [15:0] exp_sm16;
  logic [1:0]  exp_sat16 [16];
  logic [7:0]  exp_cnt16 [16];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    en      = 1'b1;
    clr     = 1'b0;
    flag    = 1'b1;

    // Reset state: counters zero, output forced low even with en=1, flag=1.
    @(negedge clk);
    #1;
    chk("rst_cnt_ovl", 32'(cnt_ovl), 32'd0);
    chk("rst_cnt_sat", 32'(cnt_sat), 32'd0);
    chk("rst_sm_ovl", 32'(sm_ovl), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;

    // Stream 1011011: overlap hits bits 4 and 7, non-overlap only bit 4.
    s7        = 7'b1011011;
    exp_ovl7  = 7'b0001001;
    exp_novl7 = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1, 1'b0);
      chk($sformatf("s7_sm_ovl[%0d]", i), 32'(sm_ovl), 32'(exp_ovl7[6-i]));
      chk($sformatf("s7_sm_novl[%0d]", i), 32'(sm_novl), 32'(exp_novl7[6-i]));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("s7_cnt_ovl", 32'(cnt_ovl), 32'd2);
    chk("s7_cnt_novl", 32'(cnt_novl), 32'd1);
    chk("s7_sm_en0", 32'(sm_ovl), 32'd0);

    // Enable gap: 1,0, three disabled cycles with flag toggling, then 1,1.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2 == 0), 1'b0, 1'b0);
      chk($sformatf("gap_sm_en0[%0d]", i), 32'(sm_ovl), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("gap_sm_b3", 32'(sm_ovl), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_sm_b4", 32'(sm_ovl), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_cnt", 32'(cnt_ovl), 32'd1);

    // Reset mid-pattern discards 1,0,1; output stays low while reset is asserted.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    flag  = 1'b1;
    en    = 1'b1;
    #1;
    chk("mid_rst_sm", 32'(sm_ovl), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_sm_after", 32'(sm_ovl), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("mid_rst_cnt", 32'(cnt_ovl), 32'd0);

    // Saturation: 1011011011011011 gives five overlapping matches; 2-bit count stops at 3.
    do_reset();
    s16       = 16'b1011011011011011;
    exp_sm16  = 16'b0001001001001001;
    exp_sat16 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                  2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_cnt16 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2,
                  8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
    for (int i = 0; i < 16; i++) begin
      step(s16[15-i], 1'b1, 1'b0);
      chk($sformatf("sat_sm[%0d]", i), 32'(sm_sat), 32'(exp_sm16[15-i]));
      chk($sformatf("sat_cnt2[%0d]", i), 32'(cnt_sat), 32'(exp_sat16[i]));
      chk($sformatf("sat_cnt8[%0d]", i), 32'(cnt_ovl), 32'(exp_cnt16[i]));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("sat_cnt2_final", 32'(cnt_sat), 32'd3);
    chk("sat_cnt8_final", 32'(cnt_ovl), 32'd5);

    // Clear: one match, then 0,1 (state 3), then flag=1 with clr=1 blocks the match.
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_pre_sm", 32'(sm_ovl), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_pre_cnt", 32'(cnt_ovl), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_sm", 32'(sm_ovl), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("clr_cnt", 32'(cnt_ovl), 32'd0);
    chk("clr_sm_b0", 32'(sm_ovl), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_sm_b1", 32'(sm_ovl), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("clr_sm_b2", 32'(sm_ovl), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_cnt_end", 32'(cnt_ovl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
